// File: rtl/encoder_frame_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_frame_timing_gen
//  Description : Bit / channel / frame timing generator for the BMQ encoder
//                datapath. Divides CLOCK_BMQ into a bit clock, keeps bit,
//                channel and frame counters, and decodes start strobes used
//                by downstream serialisers to load words and insert headers.
//  Revision    : 1.0  initial release
// ============================================================================
module encoder_frame_timing_gen #(
    parameter int BIT_DIV     = 2,
    parameter int BITS_PER_CH = 8,
    parameter int CHANNELS    = 128,
    parameter int FRAME_W     = 16,
    localparam int BW = (BITS_PER_CH > 2) ? $clog2(BITS_PER_CH) : 1,
    localparam int CW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1,
    localparam int AW = $clog2(CHANNELS + 1)
) (
    input  logic               CLOCK_BMQ,
    input  logic               RESET_BMQ,
    input  logic               Enable,
    input  logic               Sync,
    input  logic [AW-1:0]      Channels_Active,
    output logic               CLOCK_Bit,
    output logic [BW-1:0]      Counter_Bits,
    output logic [CW-1:0]      Counter_Channel,
    output logic [FRAME_W-1:0] Counter_Frame,
    output logic               Bit_Start,
    output logic               Channel_Start,
    output logic               Frame_Start,
    output logic               Frame_Wrap
);

    localparam int PW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [PW-1:0] c_PRESC_LAST = PW'(BIT_DIV - 1);
    localparam logic [PW-1:0] c_PRESC_HALF = PW'(BIT_DIV / 2);
    localparam logic [BW-1:0] c_BITS_LAST  = BW'(BITS_PER_CH - 1);
    localparam logic [AW-1:0] c_CH_MAX     = AW'(CHANNELS);

    logic [PW-1:0]      r_presc;
    logic [BW-1:0]      r_bits;
    logic [CW-1:0]      r_channel;
    logic [FRAME_W-1:0] r_frame;
    logic [AW-1:0]      r_n;
    logic               r_clk_bit;

    logic [AW-1:0]      w_ca_legal;
    logic [PW-1:0]      w_presc_next;
    logic               w_presc_last;
    logic               w_bits_last;
    logic               w_ch_last;
    logic               w_bit_start;

    // Out-of-range channel counts (0 or above the maximum) fall back to the maximum
    assign w_ca_legal = ((Channels_Active == '0) || (Channels_Active > c_CH_MAX))
                        ? c_CH_MAX : Channels_Active;

    assign w_presc_last = (r_presc == c_PRESC_LAST);
    assign w_presc_next = w_presc_last ? '0 : r_presc + PW'(1);
    assign w_bits_last  = (r_bits == c_BITS_LAST);
    // Channel index is compared against the count latched at the last frame boundary
    assign w_ch_last    = (AW'(r_channel) == (r_n - AW'(1)));

    // Timing state: Sync restarts the frame, Enable advances prescaler and counters
    always_ff @(posedge CLOCK_BMQ or posedge RESET_BMQ) begin
        if (RESET_BMQ) begin
            r_presc   <= '0;
            r_bits    <= '0;
            r_channel <= '0;
            r_frame   <= '0;
            r_clk_bit <= 1'b0;
            r_n       <= w_ca_legal;
        end else if (Sync) begin
            r_presc   <= '0;
            r_bits    <= '0;
            r_channel <= '0;
            r_clk_bit <= 1'b0;
            r_n       <= w_ca_legal;
        end else if (Enable) begin
            r_presc   <= w_presc_next;
            r_clk_bit <= (w_presc_next >= c_PRESC_HALF);
            if (w_presc_last) begin
                if (w_bits_last) begin
                    r_bits <= '0;
                    if (w_ch_last) begin
                        r_channel <= '0;
                        r_n       <= w_ca_legal;
                        r_frame   <= r_frame + FRAME_W'(1);
                    end else begin
                        r_channel <= r_channel + CW'(1);
                    end
                end else begin
                    r_bits <= r_bits + BW'(1);
                end
            end
        end
    end

    // Strobes decode the current registered state; held low during reset and Sync
    assign w_bit_start    = Enable & ~Sync & ~RESET_BMQ & (r_presc == '0);
    assign Bit_Start      = w_bit_start;
    assign Channel_Start  = w_bit_start & (r_bits == '0);
    assign Frame_Start    = w_bit_start & (r_bits == '0) & (r_channel == '0);
    assign Frame_Wrap     = w_bit_start & (r_bits == '0) & (r_channel == '0)
                            & (r_frame == '0);

    assign CLOCK_Bit       = r_clk_bit;
    assign Counter_Bits    = r_bits;
    assign Counter_Channel = r_channel;
    assign Counter_Frame   = r_frame;

endmodule
`default_nettype wire
